interrupt_controller: RTL and testbench

Programmable interrupt controller that consumes level interrupt lines from peripheral sources such as the programmable timer and UART. It latches, masks and prioritises them, then drives a single registered interrupt request to the core. Software configures and services it through the standard IO bus slave interface: mask, trigger mode, pending status, acknowledge and claim registers.

---
 rtl/interrupt_controller_pkg.sv | 9 +
 rtl/io_bus_interface.sv | 10 +
 rtl/irq_priority_encoder.sv | 16 +
 rtl/interrupt_controller.sv | 68 ++++++
 tb/tb_interrupt_controller.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: register offsets and constants shared by the interrupt controller.
package interrupt_controller_pkg;
    localparam logic [31:0] INT_REG_STATUS  = 32'h00;
    localparam logic [31:0] INT_REG_MASK    = 32'h04;
    localparam logic [31:0] INT_REG_ACK     = 32'h08;
    localparam logic [31:0] INT_REG_TRIGGER = 32'h0C;
    localparam logic [31:0] INT_REG_CLAIM   = 32'h10;
    localparam logic [31:0] CLAIM_NONE      = 32'hFFFF_FFFF;
endpackage

// File: rtl/io_bus_interface.sv
// io_bus_interface: simple register bus with single-cycle writes and 1-cycle registered reads.
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    modport slave (input write_en, read_en, address, write_data, output read_data);
    modport master (output write_en, read_en, address, write_data, input read_data);
endinterface

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: finds the lowest-numbered set bit of a vector.
module irq_priority_encoder #(
    parameter int WIDTH       = 16,
    parameter int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]       bits,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] index
);
    always_comb begin
        found = |bits;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (bits[i]) index = INDEX_WIDTH'(i);
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches, masks and prioritises source lines into one registered request.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0,
    parameter int          NUM_INTERRUPTS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    io_bus_interface.slave            io_bus,
    input  logic [NUM_INTERRUPTS-1:0] interrupt_sources,
    output logic                      interrupt_req
);
    localparam int N  = NUM_INTERRUPTS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  pending, mask, trigger, prev_sources;
    logic [N-1:0]  pending_next, src_edge, ack_bits, to_edge, wdata;
    logic          wr_mask, wr_ack, wr_trigger, found;
    logic [IW-1:0] index;
    logic [31:0]   claim, read_value;
    logic          unused_write_data;

    assign wdata             = io_bus.write_data[N-1:0];
    assign unused_write_data = ^io_bus.write_data;
    assign wr_mask           = io_bus.write_en && io_bus.address == BASE_ADDRESS + INT_REG_MASK;
    assign wr_ack            = io_bus.write_en && io_bus.address == BASE_ADDRESS + INT_REG_ACK;
    assign wr_trigger        = io_bus.write_en && io_bus.address == BASE_ADDRESS + INT_REG_TRIGGER;

    irq_priority_encoder #(.WIDTH(N), .INDEX_WIDTH(IW)) u_claim (
        .bits  (pending & mask),
        .found (found),
        .index (index)
    );

    // Edge bits keep their latch unless acked (a new edge wins); level bits follow the source,
    // except a bit just switched to edge mode starts cleared.
    always_comb begin
        src_edge     = interrupt_sources & ~prev_sources;
        ack_bits     = wr_ack ? wdata : '0;
        to_edge      = wr_trigger ? (wdata & ~trigger) : '0;
        pending_next = (trigger & ((pending & ~ack_bits) | src_edge))
                     | (~trigger & ~to_edge & interrupt_sources);
        claim        = found ? 32'(index) : CLAIM_NONE;
        read_value   = (io_bus.address == BASE_ADDRESS + INT_REG_STATUS)  ? 32'(pending) :
                       (io_bus.address == BASE_ADDRESS + INT_REG_MASK)    ? 32'(mask) :
                       (io_bus.address == BASE_ADDRESS + INT_REG_TRIGGER) ? 32'(trigger) :
                       (io_bus.address == BASE_ADDRESS + INT_REG_CLAIM)   ? claim : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending          <= '0;
            mask             <= '0;
            trigger          <= '0;
            prev_sources     <= '0;
            interrupt_req    <= 1'b0;
            io_bus.read_data <= 32'h0;
        end else begin
            prev_sources  <= interrupt_sources;
            pending       <= pending_next;
            interrupt_req <= |(pending & mask);
            if (wr_mask) mask <= wdata;
            if (wr_trigger) trigger <= wdata;
            if (io_bus.read_en) io_bus.read_data <= read_value;
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus checked against a bit-level behavioural model.
module tb_interrupt_controller;
    localparam int N = 16;
    localparam logic [31:0] STATUS = 32'h00, MASK = 32'h04, ACK = 32'h08, TRIG = 32'h0C, CLAIM = 32'h10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] src = '0;
    logic         req;
    logic [31:0]  rdata;
    int           vectors = 0;
    int           miscompares = 0;

    io_bus_interface bus ();

    interrupt_controller #(.BASE_ADDRESS(32'h0), .NUM_INTERRUPTS(N)) dut (
        .clk               (clk),
        .reset             (reset),
        .io_bus            (bus),
        .interrupt_sources (src),
        .interrupt_req     (req)
    );

    always #5 clk = ~clk;

    bit [31:0] m_pend, m_mask, m_trig, m_prev, m_rd;
    bit        m_req;

    function automatic bit [31:0] m_read(input bit [31:0] a);
        bit [31:0] on;
        on = m_pend & m_mask;
        if (a == STATUS) return m_pend;
        if (a == MASK) return m_mask;
        if (a == TRIG) return m_trig;
        if (a == CLAIM) begin
            for (int i = 0; i < N; i++) if (on[i]) return i;
            return 32'hFFFF_FFFF;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        bit [31:0] wd, np;
        bit        is_ack, is_trig;
        wd = bus.write_data & 32'h0000_FFFF;
        is_ack = bus.write_en && bus.address == ACK;
        is_trig = bus.write_en && bus.address == TRIG;
        np = 0;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_trig = 0; m_prev = 0; m_rd = 0; m_req = 0;
        end else begin
            if (bus.read_en) m_rd = m_read(bus.address);
            m_req = (m_pend & m_mask) != 0;
            for (int i = 0; i < N; i++)
                if (m_trig[i]) np[i] = (src[i] && !m_prev[i]) || (m_pend[i] && !(is_ack && wd[i]));
                else np[i] = (is_trig && wd[i]) ? 1'b0 : src[i];
            m_pend = np;
            if (bus.write_en && bus.address == MASK) m_mask = wd;
            if (is_trig) m_trig = wd;
            m_prev = 32'(src);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_req", {31'b0, req}, {31'b0, m_req});
        check("model_read_data", bus.read_data, m_rd);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.write_en = 1'b1; bus.address = a; bus.write_data = d;
        @(negedge clk);
        bus.write_en = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.read_en = 1'b1; bus.address = a;
        @(negedge clk);
        bus.read_en = 1'b0;
        rdata = bus.read_data;
        check(name, rdata, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.write_en = 1'b0; bus.read_en = 1'b0; bus.address = 0; bus.write_data = 0;
        step(3);
        reset = 1'b0;
        rdchk("reset_status", STATUS, 32'h0);
        rdchk("reset_mask", MASK, 32'h0);
        rdchk("reset_trigger", TRIG, 32'h0);
        rdchk("reset_claim", CLAIM, 32'hFFFF_FFFF);
        check("reset_req", {31'b0, req}, 32'h0);
        // edge mode pulse on source 0
        wr(TRIG, 32'h1);
        wr(MASK, 32'h1);
        src = 16'h0001;
        step(1);
        src = 16'h0000;
        check("pulse_req_1cyc", {31'b0, req}, 32'h0);
        rdchk("pulse_status", STATUS, 32'h1);
        check("pulse_req_2cyc", {31'b0, req}, 32'h1);
        wr(ACK, 32'h1);
        check("ack_req_hold", {31'b0, req}, 32'h1);
        rdchk("ack_status", STATUS, 32'h0);
        check("ack_req_drop", {31'b0, req}, 32'h0);
        // level mode claims
        wr(TRIG, 32'h0);
        wr(MASK, 32'h5);
        src = 16'h0005;
        step(2);
        rdchk("level_claim0", CLAIM, 32'h0);
        src = 16'h0004;
        step(2);
        rdchk("level_claim2", CLAIM, 32'h2);
        wr(ACK, 32'h4);
        rdchk("level_ack_noeffect", STATUS, 32'h4);
        wr(TRIG, 32'h4);
        rdchk("switch_to_edge_clears", STATUS, 32'h0);
        src = 16'h0000;
        step(2);
        // edge and ack on bit 3 in the same cycle
        wr(TRIG, 32'h8);
        src = 16'h0008;
        wr(ACK, 32'h8);
        rdchk("set_wins", STATUS, 32'h8);
        // masked edge latched, unmask later
        wr(ACK, 32'h8);
        wr(MASK, 32'h0);
        wr(TRIG, 32'hA);
        src = 16'h000A;
        step(1);
        src = 16'h0008;
        rdchk("masked_status", STATUS, 32'h2);
        check("masked_req", {31'b0, req}, 32'h0);
        wr(MASK, 32'h2);
        check("unmask_req_1edge", {31'b0, req}, 32'h0);
        step(1);
        check("unmask_req_2edge", {31'b0, req}, 32'h1);
        // address map boundaries
        rdchk("unmapped", 32'h20, 32'h0);
        wr(MASK, 32'hFFFF_FFFF);
        rdchk("mask_width", MASK, 32'h0000_FFFF);
        rdchk("claim_masked_all", CLAIM, 32'h1);
        wr(STATUS, 32'hFFFF);
        rdchk("status_ro", STATUS, 32'h2);
        // reset mid-transaction
        bus.read_en = 1'b1; bus.address = MASK; reset = 1'b1;
        step(1);
        bus.read_en = 1'b0;
        check("reset_read", bus.read_data, 32'h0);
        wr(MASK, 32'h1);
        reset = 1'b0;
        rdchk("reset_drops_write", MASK, 32'h0);
        rdchk("held_source_status", STATUS, 32'h8);
        rdchk("claim_none_after_reset", CLAIM, 32'hFFFF_FFFF);
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
